match_controller: RTL and testbench

MATCH_CONTROLLER -- requirements
Module: match_controller

---
 rtl/match_controller.sv | 166 ++++++++++++++++
 tb/tb_match_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// -----------------------------------------------------------------------------
// match_controller
// Sequences a two-player tug-of-war match. It waits for both buttons to start,
// clears the playfield, runs an arming countdown that punishes false starts,
// enables play, and scores each round. The match ends when a player reaches
// WIN_COUNT round wins.
//
// Ports
//   clk          : system clock; all state changes on its rising edge
//   reset        : synchronous, active-high; abandons any match in progress
//   L, R         : player buttons (already synchronized), high = pressed
//   round_over   : victory logic reports a finished round (read only in PLAY)
//   win_l, win_r : round-winner flags, qualified by round_over
//   field_reset  : holds the playfield and victory logic cleared while high
//   play_enable  : high only while button presses may move the rope
//   hex_l, hex_r : active-low seven-segment (gfedcba) left/right scores
//   match_over   : high once a player has reached WIN_COUNT
//   match_winner : 00 none, 01 left, 10 right (nonzero only when match over)
// -----------------------------------------------------------------------------
module match_controller #(
    parameter int WIN_COUNT  = 3,
    parameter int ARM_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic       R,
    input  logic       round_over,
    input  logic       win_l,
    input  logic       win_r,
    output logic       field_reset,
    output logic       play_enable,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r,
    output logic       match_over,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        IDLE, WAIT_REL, CLEAR, ARM, PLAY, SCORE, DONE
    } state_t;

    localparam logic [1:0] W_NONE  = 2'b00;
    localparam logic [1:0] W_LEFT  = 2'b01;
    localparam logic [1:0] W_RIGHT = 2'b10;
    localparam logic [7:0] ARM_LAST = 8'(ARM_CYCLES - 1);
    localparam logic [3:0] WIN_TGT  = 4'(WIN_COUNT);

    state_t     state, state_n;
    logic [2:0] score_l, score_l_n;
    logic [2:0] score_r, score_r_n;
    logic [7:0] cnt, cnt_n;
    logic [1:0] winner, winner_n;
    logic [3:0] inc_l, inc_r;

    // Active-low gfedcba encoding of a 0..7 score.
    function automatic logic [6:0] seg7(input logic [2:0] v);
        case (v)
            3'd0:    seg7 = 7'b1000000;
            3'd1:    seg7 = 7'b1111001;
            3'd2:    seg7 = 7'b0100100;
            3'd3:    seg7 = 7'b0110000;
            3'd4:    seg7 = 7'b0011001;
            3'd5:    seg7 = 7'b0010010;
            3'd6:    seg7 = 7'b0000010;
            default: seg7 = 7'b1111000;
        endcase
    endfunction

    // Score increment that holds at WIN_COUNT rather than wrapping.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        if ({1'b0, v} >= WIN_TGT)
            sat_inc = v;
        else
            sat_inc = v + 3'd1;
    endfunction

    assign inc_l = {1'b0, score_l} + 4'd1;
    assign inc_r = {1'b0, score_r} + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            score_l <= '0;
            score_r <= '0;
            cnt     <= '0;
            winner  <= W_NONE;
        end else begin
            state   <= state_n;
            score_l <= score_l_n;
            score_r <= score_r_n;
            cnt     <= cnt_n;
            winner  <= winner_n;
        end
    end

    always_comb begin
        state_n   = state;
        score_l_n = score_l;
        score_r_n = score_r;
        cnt_n     = cnt;
        winner_n  = winner;
        case (state)
            IDLE: begin
                if (L && R) begin
                    state_n   = WAIT_REL;
                    score_l_n = '0;
                    score_r_n = '0;
                end
            end
            WAIT_REL: begin
                if (!L && !R)
                    state_n = CLEAR;
            end
            CLEAR: begin
                state_n = ARM;
                cnt_n   = '0;
            end
            ARM: begin
                // A false start beats expiry in the same cycle.
                if (L || R)
                    state_n = CLEAR;
                else if (cnt == ARM_LAST)
                    state_n = PLAY;
                else
                    cnt_n = cnt + 8'd1;
            end
            PLAY: begin
                if (round_over) begin
                    if (win_l ^ win_r) begin
                        state_n  = SCORE;
                        winner_n = win_l ? W_LEFT : W_RIGHT;
                    end else begin
                        state_n = CLEAR;   // draw: replay the round
                    end
                end
            end
            SCORE: begin
                if (winner == W_LEFT) begin
                    score_l_n = sat_inc(score_l);
                    state_n   = (inc_l == WIN_TGT) ? DONE : CLEAR;
                end else begin
                    score_r_n = sat_inc(score_r);
                    state_n   = (inc_r == WIN_TGT) ? DONE : CLEAR;
                end
            end
            DONE: begin
                if (L && R) begin
                    state_n   = WAIT_REL;
                    score_l_n = '0;
                    score_r_n = '0;
                    winner_n  = W_NONE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign field_reset  = (state == IDLE) || (state == WAIT_REL) || (state == CLEAR);
    assign play_enable  = (state == PLAY);
    assign match_over   = (state == DONE);
    assign match_winner = (state == DONE) ? winner : W_NONE;
    assign hex_l        = seg7(score_l);
    assign hex_r        = seg7(score_r);

endmodule

// File: tb/tb_match_controller.sv
module tb_match_controller;

    logic       clk = 1'b0;
    logic       reset, L, R, round_over, win_l, win_r;
    logic       field_reset, play_enable, match_over;
    logic [6:0] hex_l, hex_r;
    logic [1:0] match_winner;

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] H0 = 7'b1000000;
    localparam logic [6:0] H1 = 7'b1111001;
    localparam logic [6:0] H2 = 7'b0100100;
    localparam logic [6:0] H3 = 7'b0110000;

    match_controller #(.WIN_COUNT(3), .ARM_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .L            (L),
        .R            (R),
        .round_over   (round_over),
        .win_l        (win_l),
        .win_r        (win_r),
        .field_reset  (field_reset),
        .play_enable  (play_enable),
        .hex_l        (hex_l),
        .hex_r        (hex_r),
        .match_over   (match_over),
        .match_winner (match_winner)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    // Starting in CLEAR: full countdown, then a round with the given flags,
    // ending one cycle after SCORE (or the draw CLEAR).
    task automatic run_round(input string tag, input logic wl, input logic wr);
        step();                                   // ARM cycle 1
        chk({tag, "_arm_fr"}, {6'd0, field_reset}, 7'd0);
        repeat (3) begin
            step();
            chk({tag, "_arm_pe"}, {6'd0, play_enable}, 7'd0);
        end
        step();                                   // PLAY
        chk({tag, "_play_pe"}, {6'd0, play_enable}, 7'd1);
        round_over = 1'b1; win_l = wl; win_r = wr;
        step();                                   // SCORE
        round_over = 1'b0; win_l = 1'b0; win_r = 1'b0;
        chk({tag, "_score_pe"}, {6'd0, play_enable}, 7'd0);
        step();                                   // CLEAR or DONE
    endtask

    initial begin
        reset = 1'b1; L = 1'b0; R = 1'b0;
        round_over = 1'b0; win_l = 1'b0; win_r = 1'b0;
        step();
        step();
        chk("rst_fr", {6'd0, field_reset}, 7'd1);
        chk("rst_pe", {6'd0, play_enable}, 7'd0);
        chk("rst_mo", {6'd0, match_over}, 7'd0);
        chk("rst_mw", {5'd0, match_winner}, 7'd0);
        chk("rst_hl", hex_l, H0);
        chk("rst_hr", hex_r, H0);

        // Start: both pressed, then released.
        reset = 1'b0; L = 1'b1; R = 1'b1;
        step();                                   // WAIT_REL
        chk("wait_fr", {6'd0, field_reset}, 7'd1);
        step();                                   // held: still WAIT_REL
        chk("wait_hold_fr", {6'd0, field_reset}, 7'd1);
        L = 1'b0; R = 1'b0;
        step();                                   // CLEAR
        chk("clear_fr", {6'd0, field_reset}, 7'd1);
        step();                                   // ARM 1
        chk("arm1_fr", {6'd0, field_reset}, 7'd0);
        chk("arm1_pe", {6'd0, play_enable}, 7'd0);
        // round_over outside PLAY must be ignored.
        round_over = 1'b1; win_l = 1'b1;
        step(); step(); step();                   // ARM 2..4
        chk("arm4_pe", {6'd0, play_enable}, 7'd0);
        round_over = 1'b0; win_l = 1'b0;
        step();                                   // PLAY
        chk("play_pe", {6'd0, play_enable}, 7'd1);
        chk("play_hl", hex_l, H0);

        // Draw: no score change, back to CLEAR.
        round_over = 1'b1; win_l = 1'b1; win_r = 1'b1;
        step();
        round_over = 1'b0; win_l = 1'b0; win_r = 1'b0;
        chk("draw_fr", {6'd0, field_reset}, 7'd1);
        chk("draw_pe", {6'd0, play_enable}, 7'd0);
        chk("draw_hl", hex_l, H0);
        chk("draw_hr", hex_r, H0);

        // False start in the 2nd ARM cycle.
        step();                                   // ARM 1
        step();                                   // ARM 2
        L = 1'b1;
        step();                                   // CLEAR
        L = 1'b0;
        chk("fs_fr", {6'd0, field_reset}, 7'd1);
        step();                                   // ARM 1
        chk("fs_arm_fr", {6'd0, field_reset}, 7'd0);
        step(); step(); step();
        chk("fs_arm4_pe", {6'd0, play_enable}, 7'd0);
        step();
        chk("fs_play_pe", {6'd0, play_enable}, 7'd1);

        // Left wins a round.
        round_over = 1'b1; win_l = 1'b1;
        step();                                   // SCORE
        round_over = 1'b0; win_l = 1'b0;
        chk("sc_fr", {6'd0, field_reset}, 7'd0);
        step();                                   // CLEAR
        chk("lw_fr", {6'd0, field_reset}, 7'd1);
        chk("lw_hl", hex_l, H1);
        chk("lw_hr", hex_r, H0);

        // Right wins two: score 1-2.
        run_round("r1", 1'b0, 1'b1);
        chk("r1_hr", hex_r, H1);
        chk("r1_fr", {6'd0, field_reset}, 7'd1);
        run_round("r2", 1'b0, 1'b1);
        chk("r2_hr", hex_r, H2);
        chk("r2_hl", hex_l, H1);
        chk("r2_mo", {6'd0, match_over}, 7'd0);

        // Reset during PLAY abandons the match.
        step(); step(); step(); step(); step();   // ARM x4, PLAY
        chk("mid_pe", {6'd0, play_enable}, 7'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_pe", {6'd0, play_enable}, 7'd0);
        chk("mid_rst_fr", {6'd0, field_reset}, 7'd1);
        chk("mid_rst_hl", hex_l, H0);
        chk("mid_rst_hr", hex_r, H0);

        // New match: right takes three rounds.
        L = 1'b1; R = 1'b1;
        step();
        L = 1'b0; R = 1'b0;
        step();                                   // CLEAR
        run_round("m1", 1'b0, 1'b1);
        chk("m1_hr", hex_r, H1);
        run_round("m2", 1'b0, 1'b1);
        chk("m2_hr", hex_r, H2);
        chk("m2_mo", {6'd0, match_over}, 7'd0);
        chk("m2_mw", {5'd0, match_winner}, 7'd0);
        run_round("m3", 1'b0, 1'b1);
        chk("done_mo", {6'd0, match_over}, 7'd1);
        chk("done_mw", {5'd0, match_winner}, 7'b0000010);
        chk("done_hr", hex_r, H3);
        chk("done_hl", hex_l, H0);
        chk("done_fr", {6'd0, field_reset}, 7'd0);
        chk("done_pe", {6'd0, play_enable}, 7'd0);

        // DONE ignores round reports and single presses.
        round_over = 1'b1; win_l = 1'b1; L = 1'b1;
        step();
        round_over = 1'b0; win_l = 1'b0; L = 1'b0;
        chk("done_hold_mo", {6'd0, match_over}, 7'd1);
        chk("done_hold_hl", hex_l, H0);

        // Restart from DONE.
        L = 1'b1; R = 1'b1;
        step();                                   // WAIT_REL
        chk("re_mo", {6'd0, match_over}, 7'd0);
        chk("re_mw", {5'd0, match_winner}, 7'd0);
        chk("re_hr", hex_r, H0);
        chk("re_fr", {6'd0, field_reset}, 7'd1);
        L = 1'b0; R = 1'b0;
        step();                                   // CLEAR
        run_round("n1", 1'b1, 1'b0);
        chk("n1_hl", hex_l, H1);
        chk("n1_hr", hex_r, H0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
